// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running h/v counters, sync/blanking decode,
// a configurable delay line matching the pattern-stage latency, and a
// registered output stage that blanks colour outside the visible area.
module vga_sync_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          SYNC_POL   = 1'b0,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic [9:0] o_px,
    output logic [9:0] o_py,
    output logic       o_frame_start,
    input  logic [2:0] i_red,
    input  logic [2:0] i_green,
    input  logic [2:0] i_blue,
    output logic [2:0] o_vga_red,
    output logic [2:0] o_vga_green,
    output logic [2:0] o_vga_blue,
    output logic       o_hsync,
    output logic       o_vsync
);

    localparam int unsigned CW      = 10;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;

    logic active_s0, hsync_s0, vsync_s0;
    logic active_dly, hsync_dly, vsync_dly;

    logic [2:0] vga_red_q, vga_red_d;
    logic [2:0] vga_green_q, vga_green_d;
    logic [2:0] vga_blue_q, vga_blue_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;

    // Next counter values: h every clock, v only on the h wrap.
    always_comb begin
        h_d = h_q + CW'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d = '0;
            end else begin
                v_d = v_q + CW'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Stage-0 decode of the visible window and sync intervals (internal active-high).
    always_comb begin
        active_s0 = (h_q < H_ACT) && (v_q < V_ACT);
        hsync_s0  = (h_q >= HS_BEGIN) && (h_q < HS_END);
        vsync_s0  = (v_q >= VS_BEGIN) && (v_q < VS_END);
    end

    if (PIPE_DELAY == 0) begin : g_no_delay
        assign active_dly = active_s0;
        assign hsync_dly  = hsync_s0;
        assign vsync_dly  = vsync_s0;
    end else begin : g_delay
        logic [PIPE_DELAY-1:0] active_sr_q, active_sr_d;
        logic [PIPE_DELAY-1:0] hsync_sr_q, hsync_sr_d;
        logic [PIPE_DELAY-1:0] vsync_sr_q, vsync_sr_d;

        // Shift stage-0 flags in at bit 0; the oldest sample sits at the top bit.
        always_comb begin
            active_sr_d    = active_sr_q;
            hsync_sr_d     = hsync_sr_q;
            vsync_sr_d     = vsync_sr_q;
            active_sr_d[0] = active_s0;
            hsync_sr_d[0]  = hsync_s0;
            vsync_sr_d[0]  = vsync_s0;
            for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
                active_sr_d[i] = active_sr_q[i-1];
                hsync_sr_d[i]  = hsync_sr_q[i-1];
                vsync_sr_d[i]  = vsync_sr_q[i-1];
            end
        end

        // Delay-line registers; reset flushes anything in flight.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                active_sr_q <= '0;
                hsync_sr_q  <= '0;
                vsync_sr_q  <= '0;
            end else begin
                active_sr_q <= active_sr_d;
                hsync_sr_q  <= hsync_sr_d;
                vsync_sr_q  <= vsync_sr_d;
            end
        end

        assign active_dly = active_sr_q[PIPE_DELAY-1];
        assign hsync_dly  = hsync_sr_q[PIPE_DELAY-1];
        assign vsync_dly  = vsync_sr_q[PIPE_DELAY-1];
    end

    // Output stage inputs: blank colour outside the window, map sync to the pin polarity.
    always_comb begin
        vga_red_d   = active_dly ? i_red   : 3'b000;
        vga_green_d = active_dly ? i_green : 3'b000;
        vga_blue_d  = active_dly ? i_blue  : 3'b000;
        hsync_d     = hsync_dly ? SYNC_POL : ~SYNC_POL;
        vsync_d     = vsync_dly ? SYNC_POL : ~SYNC_POL;
    end

    // Output registers toward the DAC.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vga_red_q   <= 3'b000;
            vga_green_q <= 3'b000;
            vga_blue_q  <= 3'b000;
            hsync_q     <= ~SYNC_POL;
            vsync_q     <= ~SYNC_POL;
        end else begin
            vga_red_q   <= vga_red_d;
            vga_green_q <= vga_green_d;
            vga_blue_q  <= vga_blue_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
        end
    end

    assign o_px          = h_q;
    assign o_py          = v_q;
    assign o_frame_start = (h_q == '0) && (v_q == '0);
    assign o_vga_red     = vga_red_q;
    assign o_vga_green   = vga_green_q;
    assign o_vga_blue    = vga_blue_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: three instances (small timing with
// PIPE_DELAY=2 and positive sync, full default timing, small timing with
// PIPE_DELAY=0) driven with random colours and random/mid-frame resets.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] px;
        logic [9:0] py;
        logic       fs;
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
        logic       hs;
        logic       vs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_r, in_g, in_b;

    logic [9:0] a_px, a_py, b_px, b_py, c_px, c_py;
    logic       a_fs, b_fs, c_fs;
    logic [2:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
    logic       a_hs, a_vs, b_hs, b_vs, c_hs, c_vs;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int checks = 0;
    int errors = 0;
    int n      = 0;
    bit done   = 1'b0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b1), .PIPE_DELAY(2)
    ) dut_a (
        .i_clk(clk), .i_reset(rst),
        .o_px(a_px), .o_py(a_py), .o_frame_start(a_fs),
        .i_red(in_r), .i_green(in_g), .i_blue(in_b),
        .o_vga_red(a_r), .o_vga_green(a_g), .o_vga_blue(a_b),
        .o_hsync(a_hs), .o_vsync(a_vs)
    );

    vga_sync_gen dut_b (
        .i_clk(clk), .i_reset(rst),
        .o_px(b_px), .o_py(b_py), .o_frame_start(b_fs),
        .i_red(in_r), .i_green(in_g), .i_blue(in_b),
        .o_vga_red(b_r), .o_vga_green(b_g), .o_vga_blue(b_b),
        .o_hsync(b_hs), .o_vsync(b_vs)
    );

    vga_sync_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(2),
        .SYNC_POL(1'b0), .PIPE_DELAY(0)
    ) dut_c (
        .i_clk(clk), .i_reset(rst),
        .o_px(c_px), .o_py(c_py), .o_frame_start(c_fs),
        .i_red(in_r), .i_green(in_g), .i_blue(in_b),
        .o_vga_red(c_r), .o_vga_green(c_g), .o_vga_blue(c_b),
        .o_hsync(c_hs), .o_vsync(c_vs)
    );

    // Expected outputs for output slot 'slot' (clocks since the last reset edge),
    // given the colour driven in the preceding clock.
    function automatic exp_t model(input int slot, input int pd, input bit pol,
                                   input int ha, input int hfp, input int hsw, input int hbp,
                                   input int va, input int vfp, input int vsw, input int vbp,
                                   input logic [2:0] cr, input logic [2:0] cg, input logic [2:0] cb);
        exp_t e;
        int   ht, vt, src, h, v;
        bit   act, hsy, vsy;
        ht   = ha + hfp + hsw + hbp;
        vt   = va + vfp + vsw + vbp;
        e.px = 10'(slot % ht);
        e.py = 10'((slot / ht) % vt);
        e.fs = ((slot % (ht * vt)) == 0);
        src  = slot - 1 - pd;
        act  = 1'b0;
        hsy  = 1'b0;
        vsy  = 1'b0;
        if (src >= 0) begin
            h   = src % ht;
            v   = (src / ht) % vt;
            act = (h < ha) && (v < va);
            hsy = (h >= ha + hfp) && (h < ha + hfp + hsw);
            vsy = (v >= va + vfp) && (v < va + vfp + vsw);
        end
        e.r  = act ? cr : 3'b000;
        e.g  = act ? cg : 3'b000;
        e.b  = act ? cb : 3'b000;
        e.hs = hsy ? pol : !pol;
        e.vs = vsy ? pol : !pol;
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare(input string tag, input exp_t e,
                           input logic [9:0] px, input logic [9:0] py, input logic fs,
                           input logic [2:0] cr, input logic [2:0] cg, input logic [2:0] cb,
                           input logic hs, input logic vs);
        check({tag, ".px"},    32'(px), 32'(e.px));
        check({tag, ".py"},    32'(py), 32'(e.py));
        check({tag, ".frame"}, 32'(fs), 32'(e.fs));
        check({tag, ".red"},   32'(cr), 32'(e.r));
        check({tag, ".green"}, 32'(cg), 32'(e.g));
        check({tag, ".blue"},  32'(cb), 32'(e.b));
        check({tag, ".hsync"}, 32'(hs), 32'(e.hs));
        check({tag, ".vsync"}, 32'(vs), 32'(e.vs));
    endtask

    // Drive one clock of stimulus and queue the expected response of the next slot.
    task automatic step(input bit rs);
        logic [2:0] cr, cg, cb;
        int         nx;
        cr   = 3'($urandom);
        cg   = 3'($urandom);
        cb   = 3'($urandom);
        rst  = rs;
        in_r = cr;
        in_g = cg;
        in_b = cb;
        nx   = rs ? 0 : n + 1;
        q_a.push_back(model(nx, 2, 1'b1, 16, 3, 5, 4, 6, 2, 2, 3, cr, cg, cb));
        q_b.push_back(model(nx, 1, 1'b0, 640, 16, 96, 48, 480, 10, 2, 33, cr, cg, cb));
        q_c.push_back(model(nx, 0, 1'b0, 10, 2, 3, 2, 4, 1, 1, 2, cr, cg, cb));
        @(posedge clk);
        #1;
        n = nx;
    endtask

    // Stimulus: long free run, a reset at (10,3) of the small instance, random resets.
    initial begin
        rst  = 1'b1;
        in_r = 3'b000;
        in_g = 3'b000;
        in_b = 3'b000;
        repeat (3) step(1'b1);
        repeat (1900) step(1'b0);
        step(1'b1);
        repeat (94) step(1'b0);
        step(1'b1);
        repeat (500) step(1'b0);
        repeat (3) begin
            repeat ($urandom_range(5, 300)) step(1'b0);
            step(1'b1);
        end
        repeat (50) step(1'b0);
        done = 1'b1;
    end

    // Monitor: pop and compare one expectation per instance each slot, away from the edge.
    always @(negedge clk) begin
        exp_t e;
        int   cyc;
        cyc++;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            compare("a", e, a_px, a_py, a_fs, a_r, a_g, a_b, a_hs, a_vs);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            compare("b", e, b_px, b_py, b_fs, b_r, b_g, b_b, b_hs, b_vs);
        end
        if (q_c.size() > 0) begin
            e = q_c.pop_front();
            compare("c", e, c_px, c_py, c_fs, c_r, c_g, c_b, c_hs, c_vs);
        end
        if (done || cyc > 20000) begin
            check("timeout", 32'(cyc > 20000), 32'd0);
            check("drain_a", 32'(q_a.size()), 32'd0);
            check("drain_b", 32'(q_b.size()), 32'd0);
            check("drain_c", 32'(q_c.size()), 32'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

endmodule
